// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants: immediate extension modes and default widths
package mips_pkg;

   localparam logic [1:0] EXT_SIGN   = 2'b00;
   localparam logic [1:0] EXT_ZERO   = 2'b01;
   localparam logic [1:0] EXT_UPPER  = 2'b10;
   localparam logic [1:0] EXT_BRANCH = 2'b11;

   localparam int NBITS_IN  = 16;
   localparam int NBITS_OUT = 32;

endpackage

// File: rtl/extensor_signo_core.sv
// rtl/extensor_signo_core.sv - combinational immediate extension by mode
module extensor_signo_core
   import mips_pkg::*;
#(
   parameter int NBITS_IN  = mips_pkg::NBITS_IN,
   parameter int NBITS_OUT = mips_pkg::NBITS_OUT
) (
   input  logic [NBITS_IN-1:0]  signal,
   input  logic [1:0]           extension_mode,
   output logic [NBITS_OUT-1:0] ext_signal
);

   localparam int NBITS_PAD = NBITS_OUT - NBITS_IN;

   logic [NBITS_OUT-1:0] sign_ext;
   logic [NBITS_OUT-1:0] zero_ext;
   logic [NBITS_OUT-1:0] upper_ext;
   logic [NBITS_OUT-1:0] branch_ext;

   assign sign_ext   = {{NBITS_PAD{signal[NBITS_IN-1]}}, signal};
   assign zero_ext   = {{NBITS_PAD{1'b0}}, signal};
   assign upper_ext  = {signal, {NBITS_PAD{1'b0}}};
   // Branch offsets are word counts; the two bits shifted past the MSB are dropped.
   assign branch_ext = {sign_ext[NBITS_OUT-3:0], 2'b00};

   always_comb begin
      ext_signal = sign_ext;
      case (extension_mode)
         EXT_SIGN:   ext_signal = sign_ext;
         EXT_ZERO:   ext_signal = zero_ext;
         EXT_UPPER:  ext_signal = upper_ext;
         EXT_BRANCH: ext_signal = branch_ext;
         default:    ext_signal = sign_ext;
      endcase
   end

endmodule

// File: rtl/extensor_signo.sv
// rtl/extensor_signo.sv - registered immediate extension stage aligned to the decode pipeline
module extensor_signo
   import mips_pkg::*;
#(
   parameter int NBITS_IN  = mips_pkg::NBITS_IN,
   parameter int NBITS_OUT = mips_pkg::NBITS_OUT
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic [NBITS_IN-1:0]  i_signal,
   input  logic [1:0]           i_extension_mode,
   output logic [NBITS_OUT-1:0] o_ext_signal,
   output logic                 o_valid
);

   logic [NBITS_OUT-1:0] ext_next;

   extensor_signo_core #(
      .NBITS_IN  (NBITS_IN),
      .NBITS_OUT (NBITS_OUT)
   ) u_core (
      .signal         (i_signal),
      .extension_mode (i_extension_mode),
      .ext_signal     (ext_next)
   );

   // Data holds across invalid cycles; only the valid flag drops.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_ext_signal <= '0;
         o_valid      <= 1'b0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) begin
            o_ext_signal <= ext_next;
         end
      end
   end

endmodule

// File: tb/tb_extensor_signo.sv
// tb/tb_extensor_signo.sv - scoreboard bench for extensor_signo against an arithmetic reference
module tb_extensor_signo;
   import mips_pkg::*;

   logic        clk;
   logic        i_reset;
   logic        i_valid;
   logic [15:0] i_signal;
   logic [1:0]  i_extension_mode;
   logic [31:0] o_ext_signal;
   logic        o_valid;

   typedef struct {
      logic        valid;
      logic [31:0] data;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          passes = 0;
   logic [31:0] model_data = 32'h0;
   logic        model_valid = 1'b0;

   extensor_signo #(.NBITS_IN(16), .NBITS_OUT(32)) dut (
      .i_clk            (clk),
      .i_reset          (i_reset),
      .i_valid          (i_valid),
      .i_signal         (i_signal),
      .i_extension_mode (i_extension_mode),
      .o_ext_signal     (o_ext_signal),
      .o_valid          (o_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed/unsigned integer arithmetic on the immediate, truncated to 32 bits.
   function automatic logic [31:0] ref_ext(input logic [15:0] s, input logic [1:0] m);
      longint sv;
      longint uv;
      longint r;
      sv = longint'($signed(s));
      uv = longint'(s);
      case (m)
         2'd0:    r = sv;
         2'd1:    r = uv;
         2'd2:    r = uv * 65536;
         default: r = sv * 4;
      endcase
      return r[31:0];
   endfunction

   task automatic step(input logic rst, input logic v, input logic [15:0] s,
                       input logic [1:0] m, input string tag);
      exp_t e;
      i_reset          = rst;
      i_valid          = v;
      i_signal         = s;
      i_extension_mode = m;
      if (rst) begin
         model_data  = 32'h0;
         model_valid = 1'b0;
      end else if (v) begin
         model_data  = ref_ext(s, m);
         model_valid = 1'b1;
      end else begin
         model_valid = 1'b0;
      end
      e.valid = model_valid;
      e.data  = model_data;
      e.tag   = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: each falling edge reflects the preceding rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (o_valid === e.valid) passes++;
            else $display("FAIL %s o_valid got %0b expected %0b", e.tag, o_valid, e.valid);
            checks++;
            if (o_ext_signal === e.data) passes++;
            else $display("FAIL %s o_ext_signal got %h expected %h", e.tag, o_ext_signal, e.data);
         end
      end
   end

   initial begin
      logic [15:0] rs;
      logic [1:0]  rm;
      logic        rv;
      logic        rr;
      i_reset = 1'b1; i_valid = 1'b1; i_signal = 16'hFFFF; i_extension_mode = EXT_SIGN;

      step(1'b1, 1'b1, 16'hFFFF, EXT_SIGN, "reset0");
      step(1'b1, 1'b1, 16'hFFFF, EXT_SIGN, "reset1");

      for (int m = 0; m < 4; m++) step(1'b0, 1'b1, 16'h8000, 2'(m), "neg_imm");
      for (int m = 0; m < 4; m++) step(1'b0, 1'b1, 16'h7FFF, 2'(m), "pos_imm");

      step(1'b0, 1'b1, 16'h1234, EXT_ZERO, "gate_load");
      step(1'b0, 1'b0, 16'hABCD, EXT_ZERO, "gate_hold");
      step(1'b0, 1'b0, 16'h5555, EXT_UPPER, "gate_hold2");

      for (int k = 0; k < 6; k++)
         step(1'b0, 1'b1, 16'h8001, (k % 2 == 0) ? EXT_SIGN : EXT_UPPER, "b2b");
      step(1'b1, 1'b1, 16'h8001, EXT_SIGN, "mid_reset");
      step(1'b0, 1'b1, 16'h8001, EXT_UPPER, "post_reset");
      step(1'b0, 1'b1, 16'h0003, EXT_BRANCH, "post_reset2");

      for (int k = 0; k < 300; k++) begin
         rs = 16'($urandom);
         rm = 2'($urandom_range(0, 3));
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 19) == 0);
         step(rr, rv, rs, rm, "random");
      end
      step(1'b0, 1'b0, 16'h0000, EXT_SIGN, "tail");

      for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(posedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         $display("FAIL drain queue left %0d expected 0", sb_q.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
